// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller: load-use stall, redirect flush and memory-busy hold sequencing
// for the 5-stage pipeline, with saturating stall/flush event counters.
module pipeline_hazard_controller #(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      ins,
    input  logic             branch_taken,
    input  logic             mem_busy,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_bubble,
    output logic             if_flush,
    output logic [1:0]       hz_state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    typedef enum logic [1:0] {RUN = 2'b00, FLUSH = 2'b01} state_t;
    state_t           state_q, state_d;
    logic [3:0]       fcnt_q, fcnt_d;
    logic             ld_valid_q, ld_valid_d;
    logic [4:0]       ld_rd_q, ld_rd_d;
    logic [CNT_W-1:0] stall_q, stall_d, flush_q, flush_d;
    logic [5:0] op;
    logic       is_ld, is_jmp, is_cj, hazard, redirect, in_flush, run_redir, run_haz;
    logic       unused_bits;
    assign unused_bits = &{1'b0, ins[10:0]};
    assign op       = ins[31:26];
    assign is_ld    = op == 6'b010100;
    assign is_jmp   = op == 6'b011000;
    assign is_cj    = op[5:2] == 4'b0111;
    assign hazard   = ld_valid_q & (ld_rd_q != 5'd0) & (ins[20:16] == ld_rd_q | ins[15:11] == ld_rd_q)
                      & ~is_jmp & ~is_cj;
    assign redirect = is_jmp | (is_cj & branch_taken);
    assign in_flush = state_q == FLUSH;
    assign run_redir = ~mem_busy & ~in_flush & redirect;
    assign run_haz   = ~mem_busy & ~in_flush & ~redirect & hazard;
    assign pc_en        = ~mem_busy & ~run_haz;
    assign if_id_en     = ~mem_busy & ~run_haz;
    assign id_ex_bubble = ~mem_busy & (in_flush | run_haz);
    assign if_flush     = ~mem_busy & (in_flush | run_redir);
    assign hz_state     = mem_busy ? 2'b10 : in_flush ? 2'b01 : 2'b00;
    assign stall_cnt    = stall_q;
    assign flush_cnt    = flush_q;
    always_comb begin
        state_d    = state_q;
        fcnt_d     = fcnt_q;
        ld_valid_d = ld_valid_q;
        ld_rd_d    = ld_rd_q;
        stall_d    = stall_q;
        flush_d    = flush_q;
        // mem_busy leaves every register untouched so the sequence resumes where it stopped
        if (!mem_busy) begin
            if (in_flush) begin
                ld_valid_d = 1'b0;
                fcnt_d     = fcnt_q - 4'd1;
                state_d    = fcnt_q == 4'd1 ? RUN : FLUSH;
            end else if (redirect) begin
                ld_valid_d = 1'b0;
                flush_d    = flush_q + CNT_W'(flush_q != '1);
                fcnt_d     = 4'(FLUSH_CYCLES - 1);
                state_d    = FLUSH_CYCLES == 1 ? RUN : FLUSH;
            end else if (hazard) begin
                ld_valid_d = 1'b0;
                stall_d    = stall_q + CNT_W'(stall_q != '1);
                state_d    = RUN;
            end else begin
                ld_valid_d = is_ld;
                ld_rd_d    = ins[25:21];
                state_d    = RUN;
            end
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= RUN;
            fcnt_q     <= 4'd0;
            ld_valid_q <= 1'b0;
            ld_rd_q    <= 5'd0;
            stall_q    <= '0;
            flush_q    <= '0;
        end else begin
            state_q    <= state_d;
            fcnt_q     <= fcnt_d;
            ld_valid_q <= ld_valid_d;
            ld_rd_q    <= ld_rd_d;
            stall_q    <= stall_d;
            flush_q    <= flush_d;
        end
    end
endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// tb_pipeline_hazard_controller: directed and random stimulus scored against a cycle-level
// reference model through an expected-response queue.
module tb_pipeline_hazard_controller;
    localparam int FC  = 3;
    localparam int CW  = 3;
    localparam int CAP = (1 << CW) - 1;
    localparam logic [5:0] LD = 6'b010100, JMP = 6'b011000, CJ = 6'b011100, ALU = 6'b000000;
    logic          clk = 1'b0, reset = 1'b1, branch_taken = 1'b0, mem_busy = 1'b0;
    logic [31:0]   ins = '0;
    logic          pc_en, if_id_en, id_ex_bubble, if_flush;
    logic [1:0]    hz_state;
    logic [CW-1:0] stall_cnt, flush_cnt;
    pipeline_hazard_controller #(.FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .ins(ins), .branch_taken(branch_taken), .mem_busy(mem_busy),
        .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_bubble(id_ex_bubble), .if_flush(if_flush),
        .hz_state(hz_state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );
    always #5 clk = ~clk;
    typedef struct {
        logic [5:0] ctl;
        int         st;
        int         fl;
    } exp_t;
    exp_t q[$];
    int vectors = 0, miscompares = 0;
    int pend = -1, fleft = 0, stalls = 0, flushes = 0;
    function automatic logic [31:0] mk(input logic [5:0] op, input int rd, input int ra, input int rb);
        return {op, 5'(rd), 5'(ra), 5'(rb), 11'd0};
    endfunction
    // Model: pend = destination of the previous load (-1 none), fleft = squashed slots still owed
    task automatic step(input logic [31:0] i, input logic b, input logic m, input logic r);
        exp_t e;
        logic [5:0] op;
        int ra, rb;
        @(posedge clk);
        #1;
        reset = r;
        ins = r ? 32'd0 : i;
        branch_taken = r ? 1'b0 : b;
        mem_busy = r ? 1'b0 : m;
        op = ins[31:26];
        ra = int'(ins[20:16]);
        rb = int'(ins[15:11]);
        if (r) begin
            pend = -1; fleft = 0; stalls = 0; flushes = 0;
        end
        e.st = stalls;
        e.fl = flushes;
        if (r) e.ctl = 6'b110000;
        else if (mem_busy) e.ctl = 6'b000010;
        else if (fleft > 0) begin
            e.ctl = 6'b111101; fleft--; pend = -1;
        end else if (op == JMP || (op[5:2] == 4'b0111 && branch_taken)) begin
            e.ctl = 6'b110100; flushes = flushes < CAP ? flushes + 1 : CAP; fleft = FC - 1; pend = -1;
        end else if (pend > 0 && (ra == pend || rb == pend) && op != JMP && op[5:2] != 4'b0111) begin
            e.ctl = 6'b001000; stalls = stalls < CAP ? stalls + 1 : CAP; pend = -1;
        end else begin
            e.ctl = 6'b110000; pend = op == LD ? int'(ins[25:21]) : -1;
        end
        q.push_back(e);
    endtask
    always @(negedge clk) begin
        exp_t e;
        logic [5:0] a;
        if (q.size() != 0) begin
            e = q.pop_front();
            a = {pc_en, if_id_en, id_ex_bubble, if_flush, hz_state};
            vectors++;
            if (a !== e.ctl || stall_cnt !== CW'(e.st) || flush_cnt !== CW'(e.fl)) begin
                miscompares++;
                $display("FAIL vec%0d ctl/stall/flush got %b/%0d/%0d expected %b/%0d/%0d",
                         vectors, a, stall_cnt, flush_cnt, e.ctl, e.st, e.fl);
            end
        end
    end
    initial begin
        logic [31:0] nop;
        logic [5:0] op;
        nop = mk(ALU, 1, 2, 3);
        step(nop, 0, 0, 1);
        step(nop, 0, 0, 1);
        step(mk(LD, 5, 0, 0), 0, 0, 0);
        step(mk(ALU, 6, 5, 1), 0, 0, 0);
        step(mk(ALU, 6, 5, 1), 0, 0, 0);
        step(mk(LD, 0, 5, 0), 0, 0, 0);
        step(mk(ALU, 1, 0, 5), 0, 0, 0);
        step(mk(LD, 3, 1, 1), 0, 0, 0);
        step(mk(ALU, 2, 4, 4), 0, 0, 0);
        step(mk(LD, 7, 1, 1), 0, 0, 0);
        step(mk(LD, 7, 7, 0), 0, 0, 0);
        step(mk(LD, 7, 7, 0), 0, 0, 0);
        step(mk(JMP, 0, 0, 0), 0, 0, 0);
        repeat (FC) step(nop, 0, 0, 0);
        step(mk(CJ, 0, 0, 0), 0, 0, 0);
        step(nop, 0, 0, 0);
        step(mk(CJ, 0, 0, 0), 1, 0, 0);
        repeat (FC) step(nop, 0, 0, 0);
        step(mk(LD, 5, 0, 0), 0, 0, 0);
        repeat (3) step(mk(ALU, 2, 5, 0), 0, 1, 0);
        repeat (2) step(mk(ALU, 2, 5, 0), 0, 0, 0);
        step(mk(JMP, 0, 0, 0), 0, 0, 0);
        step(nop, 0, 1, 0);
        repeat (FC) step(nop, 0, 0, 0);
        step(mk(JMP, 0, 0, 0), 0, 0, 0);
        step(nop, 0, 0, 1);
        step(nop, 0, 0, 0);
        step(nop, 0, 1, 0);
        step(nop, 0, 0, 1);
        repeat (600) begin
            case ($urandom_range(0, 4))
                0: op = LD;
                1: op = JMP;
                2: op = {4'b0111, 2'($urandom_range(0, 3))};
                3: op = ALU;
                default: op = 6'($urandom_range(0, 63));
            endcase
            step(mk(op, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), $urandom_range(0, 6) == 0, $urandom_range(0, 99) == 0);
        end
        for (int k = 0; k < 10 && q.size() != 0; k++) @(negedge clk);
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain pending=%0d expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
